pspin_her_arbiter: RTL and testbench

Multi-port handler-execution-request (HER) arbiter that merges HER streams from NUM_PORTS independent ingress datapaths into the single HER interface of the PsPIN wrapper, and routes PsPIN feedback back to the originating port. It sits between the per-port HER generators and the PsPIN wrapper. It tags each forwarded HER with its source port in the upper msgid bits. It enforces a per-port outstanding-HER limit so one port cannot exhaust handler capacity, and supports round-robin or fixed-priority arbitration.

---
 rtl/pspin_her_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_pspin_her_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_her_arbiter.sv
// Merges per-port HER streams into the single PsPIN HER interface, tags each
// HER with its source port, limits outstanding HERs per port and routes
// feedback back to the originating port.
module pspin_her_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int MSG_ID_WIDTH    = 10,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 16,
   parameter int ARB_MODE        = 0,
   localparam int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_PORTS-1:0]               s_her_valid,
   output logic [NUM_PORTS-1:0]               s_her_ready,
   input  logic [NUM_PORTS*MSG_ID_WIDTH-1:0]  s_her_msgid,
   input  logic [NUM_PORTS-1:0]               s_her_is_eom,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    s_her_addr,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    s_her_size,
   output logic                               m_her_valid,
   input  logic                               m_her_ready,
   output logic [PORT_W+MSG_ID_WIDTH-1:0]     m_her_msgid,
   output logic                               m_her_is_eom,
   output logic [ADDR_WIDTH-1:0]              m_her_addr,
   output logic [ADDR_WIDTH-1:0]              m_her_size,
   input  logic                               s_fb_valid,
   output logic                               s_fb_ready,
   input  logic [PORT_W+MSG_ID_WIDTH-1:0]     s_fb_msgid,
   input  logic [ADDR_WIDTH-1:0]              s_fb_addr,
   input  logic [ADDR_WIDTH-1:0]              s_fb_size,
   output logic [NUM_PORTS-1:0]               m_fb_valid,
   input  logic [NUM_PORTS-1:0]               m_fb_ready,
   output logic [NUM_PORTS*MSG_ID_WIDTH-1:0]  m_fb_msgid,
   output logic [NUM_PORTS*ADDR_WIDTH-1:0]    m_fb_addr,
   output logic [NUM_PORTS*ADDR_WIDTH-1:0]    m_fb_size,
   output logic [NUM_PORTS*CNT_W-1:0]         outstanding,
   output logic                               fb_err
);

   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PORT_W:0]   NP_EXT  = (PORT_W+1)'(NUM_PORTS);

   logic [CNT_W-1:0]              cnt_q [NUM_PORTS];
   logic [CNT_W-1:0]              cnt_d [NUM_PORTS];
   logic [PORT_W-1:0]             rr_ptr_q, rr_ptr_d;

   logic                          her_valid_q;
   logic [PORT_W+MSG_ID_WIDTH-1:0] her_msgid_q;
   logic                          her_eom_q;
   logic [ADDR_WIDTH-1:0]         her_addr_q, her_size_q;

   logic [NUM_PORTS-1:0]              fb_valid_q;
   logic [NUM_PORTS*MSG_ID_WIDTH-1:0] fb_msgid_q;
   logic [NUM_PORTS*ADDR_WIDTH-1:0]   fb_addr_q, fb_size_q;
   logic                              fb_err_q;

   logic                      loadable, grant_valid, her_fire;
   logic [PORT_W-1:0]         grant_idx;
   logic [PORT_W:0]           cand;
   logic [NUM_PORTS-1:0]      eligible;
   logic [MSG_ID_WIDTH-1:0]   sel_msgid;
   logic                      sel_eom;
   logic [ADDR_WIDTH-1:0]     sel_addr, sel_size;

   logic [PORT_W-1:0]         fb_port;
   logic                      fb_in_range, fb_slot_free, fb_cnt_zero;
   logic                      fb_fire, fb_bad, fb_fwd;

   // Eligibility, grant selection (round-robin or fixed priority) and source mux.
   always_comb begin
      loadable    = !her_valid_q || m_her_ready;
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      sel_msgid   = '0;
      sel_eom     = 1'b0;
      sel_addr    = '0;
      sel_size    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         eligible[i] = s_her_valid[i] && (cnt_q[i] < MAX_CNT);
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (ARB_MODE == 1) cand = (PORT_W+1)'(k);
         else               cand = {1'b0, rr_ptr_q} + (PORT_W+1)'(k);
         if (cand >= NP_EXT) cand = cand - NP_EXT;
         if (!grant_valid && eligible[cand[PORT_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[PORT_W-1:0];
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_idx == PORT_W'(i)) begin
            sel_msgid = s_her_msgid[i*MSG_ID_WIDTH +: MSG_ID_WIDTH];
            sel_eom   = s_her_is_eom[i];
            sel_addr  = s_her_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_size  = s_her_size[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
      her_fire    = loadable && grant_valid;
      s_her_ready = her_fire ? (NUM_PORTS'(1) << grant_idx) : '0;
      rr_ptr_d    = rr_ptr_q;
      if (her_fire) begin
         rr_ptr_d = (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // Feedback decode: error cases (unknown port, nothing outstanding) are
   // always accepted and dropped so PsPIN can never be stalled by them.
   always_comb begin
      fb_port      = s_fb_msgid[MSG_ID_WIDTH +: PORT_W];
      fb_in_range  = 1'b0;
      fb_slot_free = 1'b1;
      fb_cnt_zero  = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (fb_port == PORT_W'(i)) begin
            fb_in_range  = 1'b1;
            fb_slot_free = !fb_valid_q[i] || m_fb_ready[i];
            fb_cnt_zero  = (cnt_q[i] == '0);
         end
      end
      fb_bad     = !fb_in_range || fb_cnt_zero;
      s_fb_ready = fb_bad || fb_slot_free;
      fb_fire    = s_fb_valid && s_fb_ready;
      fb_fwd     = fb_fire && !fb_bad;
   end

   // Per-port outstanding counters; increment and decrement cancel on the same port.
   always_comb begin
      outstanding = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cnt_d[i] = cnt_q[i]
                  + CNT_W'(her_fire && (grant_idx == PORT_W'(i)))
                  - CNT_W'(fb_fwd && (fb_port == PORT_W'(i)));
         outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   // HER output slot, round-robin pointer, counters and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         her_valid_q <= 1'b0;
         her_msgid_q <= '0;
         her_eom_q   <= 1'b0;
         her_addr_q  <= '0;
         her_size_q  <= '0;
         rr_ptr_q    <= '0;
         fb_err_q    <= 1'b0;
         for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
      end else begin
         if (her_fire) begin
            her_valid_q <= 1'b1;
            her_msgid_q <= {grant_idx, sel_msgid};
            her_eom_q   <= sel_eom;
            her_addr_q  <= sel_addr;
            her_size_q  <= sel_size;
         end else if (m_her_ready) begin
            her_valid_q <= 1'b0;
         end
         rr_ptr_q <= rr_ptr_d;
         if (fb_fire && fb_bad) fb_err_q <= 1'b1;
         for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Per-port one-deep feedback output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_valid_q <= '0;
         fb_msgid_q <= '0;
         fb_addr_q  <= '0;
         fb_size_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (fb_fwd && (fb_port == PORT_W'(i))) begin
               fb_valid_q[i]                                 <= 1'b1;
               fb_msgid_q[i*MSG_ID_WIDTH +: MSG_ID_WIDTH]    <= s_fb_msgid[MSG_ID_WIDTH-1:0];
               fb_addr_q[i*ADDR_WIDTH +: ADDR_WIDTH]         <= s_fb_addr;
               fb_size_q[i*ADDR_WIDTH +: ADDR_WIDTH]         <= s_fb_size;
            end else if (m_fb_ready[i]) begin
               fb_valid_q[i] <= 1'b0;
            end
         end
      end
   end

   assign m_her_valid  = her_valid_q;
   assign m_her_msgid  = her_msgid_q;
   assign m_her_is_eom = her_eom_q;
   assign m_her_addr   = her_addr_q;
   assign m_her_size   = her_size_q;
   assign m_fb_valid   = fb_valid_q;
   assign m_fb_msgid   = fb_msgid_q;
   assign m_fb_addr    = fb_addr_q;
   assign m_fb_size    = fb_size_q;
   assign fb_err       = fb_err_q;

endmodule

// File: tb/tb_pspin_her_arbiter.sv
// Directed bench for pspin_her_arbiter. Two instances share stimulus:
// dut_a is round-robin with a limit of 4, dut_b is fixed priority with a limit of 2.
module tb_pspin_her_arbiter;

   localparam int NP = 2;
   localparam int MW = 10;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [NP-1:0]       s_her_valid;
   logic [NP*MW-1:0]    s_her_msgid;
   logic [NP-1:0]       s_her_is_eom;
   logic [NP*AW-1:0]    s_her_addr, s_her_size;
   logic                m_her_ready;
   logic                s_fb_valid;
   logic [MW:0]         s_fb_msgid;
   logic [AW-1:0]       s_fb_addr, s_fb_size;
   logic [NP-1:0]       m_fb_ready;

   logic [NP-1:0]    a_s_her_ready, b_s_her_ready;
   logic             a_m_her_valid, b_m_her_valid;
   logic [MW:0]      a_m_her_msgid, b_m_her_msgid;
   logic             a_m_her_is_eom, b_m_her_is_eom;
   logic [AW-1:0]    a_m_her_addr, b_m_her_addr, a_m_her_size, b_m_her_size;
   logic             a_s_fb_ready, b_s_fb_ready;
   logic [NP-1:0]    a_m_fb_valid, b_m_fb_valid;
   logic [NP*MW-1:0] a_m_fb_msgid, b_m_fb_msgid;
   logic [NP*AW-1:0] a_m_fb_addr, b_m_fb_addr, a_m_fb_size, b_m_fb_size;
   logic [5:0]       a_outstanding;
   logic [3:0]       b_outstanding;
   logic             a_fb_err, b_fb_err;

   int n_cmp = 0;
   int n_err = 0;

   pspin_her_arbiter #(.NUM_PORTS(NP), .MSG_ID_WIDTH(MW), .ADDR_WIDTH(AW),
                       .MAX_OUTSTANDING(4), .ARB_MODE(0)) dut_a (
      .clk(clk), .rst(rst),
      .s_her_valid(s_her_valid), .s_her_ready(a_s_her_ready), .s_her_msgid(s_her_msgid),
      .s_her_is_eom(s_her_is_eom), .s_her_addr(s_her_addr), .s_her_size(s_her_size),
      .m_her_valid(a_m_her_valid), .m_her_ready(m_her_ready), .m_her_msgid(a_m_her_msgid),
      .m_her_is_eom(a_m_her_is_eom), .m_her_addr(a_m_her_addr), .m_her_size(a_m_her_size),
      .s_fb_valid(s_fb_valid), .s_fb_ready(a_s_fb_ready), .s_fb_msgid(s_fb_msgid),
      .s_fb_addr(s_fb_addr), .s_fb_size(s_fb_size),
      .m_fb_valid(a_m_fb_valid), .m_fb_ready(m_fb_ready), .m_fb_msgid(a_m_fb_msgid),
      .m_fb_addr(a_m_fb_addr), .m_fb_size(a_m_fb_size),
      .outstanding(a_outstanding), .fb_err(a_fb_err));

   pspin_her_arbiter #(.NUM_PORTS(NP), .MSG_ID_WIDTH(MW), .ADDR_WIDTH(AW),
                       .MAX_OUTSTANDING(2), .ARB_MODE(1)) dut_b (
      .clk(clk), .rst(rst),
      .s_her_valid(s_her_valid), .s_her_ready(b_s_her_ready), .s_her_msgid(s_her_msgid),
      .s_her_is_eom(s_her_is_eom), .s_her_addr(s_her_addr), .s_her_size(s_her_size),
      .m_her_valid(b_m_her_valid), .m_her_ready(m_her_ready), .m_her_msgid(b_m_her_msgid),
      .m_her_is_eom(b_m_her_is_eom), .m_her_addr(b_m_her_addr), .m_her_size(b_m_her_size),
      .s_fb_valid(s_fb_valid), .s_fb_ready(b_s_fb_ready), .s_fb_msgid(s_fb_msgid),
      .s_fb_addr(s_fb_addr), .s_fb_size(s_fb_size),
      .m_fb_valid(b_m_fb_valid), .m_fb_ready(m_fb_ready), .m_fb_msgid(b_m_fb_msgid),
      .m_fb_addr(b_m_fb_addr), .m_fb_size(b_m_fb_size),
      .outstanding(b_outstanding), .fb_err(b_fb_err));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst          = 1'b1;
      s_her_valid  = '0;
      s_her_msgid  = {10'h022, 10'h011};
      s_her_is_eom = 2'b10;
      s_her_addr   = {32'hB000_0001, 32'hA000_0000};
      s_her_size   = {32'd128, 32'd64};
      m_her_ready  = 1'b0;
      s_fb_valid   = 1'b0;
      s_fb_msgid   = '0;
      s_fb_addr    = '0;
      s_fb_size    = '0;
      m_fb_ready   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      #1;
      n_cmp++; if (a_m_her_valid !== 1'b0) begin n_err++; $display("FAIL reset_her_valid got=%b exp=0", a_m_her_valid); end
      n_cmp++; if (a_m_fb_valid !== 2'b00) begin n_err++; $display("FAIL reset_fb_valid got=%b exp=00", a_m_fb_valid); end
      n_cmp++; if (a_outstanding !== 6'd0) begin n_err++; $display("FAIL reset_outstanding_a got=%h exp=0", a_outstanding); end
      n_cmp++; if (b_outstanding !== 4'd0) begin n_err++; $display("FAIL reset_outstanding_b got=%h exp=0", b_outstanding); end
      n_cmp++; if (a_fb_err !== 1'b0) begin n_err++; $display("FAIL reset_fb_err got=%b exp=0", a_fb_err); end
      n_cmp++; if (a_s_her_ready !== 2'b00) begin n_err++; $display("FAIL reset_her_ready got=%b exp=00", a_s_her_ready); end
      n_cmp++; if (a_s_fb_ready !== 1'b1) begin n_err++; $display("FAIL reset_fb_ready got=%b exp=1", a_s_fb_ready); end
      n_cmp++; if (a_m_her_msgid !== 11'd0) begin n_err++; $display("FAIL reset_her_msgid got=%h exp=0", a_m_her_msgid); end
   endtask

   task automatic test_round_robin;
      logic [1:0]  exp_rdy;
      logic [10:0] exp_id;
      logic [31:0] exp_addr;
      do_reset();
      m_her_ready = 1'b1;
      m_fb_ready  = 2'b11;
      s_her_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_id   = (k % 2 == 0) ? 11'h011 : 11'h422;
         exp_addr = (k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0001;
         #1;
         n_cmp++; if (a_s_her_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, a_s_her_ready, exp_rdy); end
         tick();
         n_cmp++; if (a_m_her_valid !== 1'b1 || a_m_her_msgid !== exp_id) begin n_err++; $display("FAIL rr_her k=%0d got=%b/%h exp=1/%h", k, a_m_her_valid, a_m_her_msgid, exp_id); end
         n_cmp++; if (a_m_her_addr !== exp_addr) begin n_err++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, a_m_her_addr, exp_addr); end
      end
      s_her_valid = 2'b00;
      #1;
      n_cmp++; if (a_outstanding !== 6'b010_010) begin n_err++; $display("FAIL rr_outstanding got=%b exp=010010", a_outstanding); end
   endtask

   task automatic test_fixed_priority;
      logic [1:0] exp_g [5];
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b10; exp_g[4] = 2'b00;
      do_reset();
      m_her_ready = 1'b1;
      s_her_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if (b_s_her_ready !== exp_g[k]) begin n_err++; $display("FAIL fp_ready k=%0d got=%b exp=%b", k, b_s_her_ready, exp_g[k]); end
         tick();
         if (k == 2) begin
            n_cmp++; if (b_m_her_msgid !== 11'h422) begin n_err++; $display("FAIL fp_msgid got=%h exp=422", b_m_her_msgid); end
         end
      end
      n_cmp++; if (b_outstanding !== 4'b1010) begin n_err++; $display("FAIL fp_outstanding got=%b exp=1010", b_outstanding); end
      n_cmp++; if (b_m_her_valid !== 1'b0) begin n_err++; $display("FAIL fp_drained got=%b exp=0", b_m_her_valid); end
      s_her_valid = 2'b00;
   endtask

   task automatic test_limit_feedback;
      do_reset();
      m_her_ready = 1'b1;
      s_her_valid = 2'b01;
      tick();
      tick();
      n_cmp++; if (b_s_her_ready !== 2'b00) begin n_err++; $display("FAIL lim_held got=%b exp=00", b_s_her_ready); end
      n_cmp++; if (b_outstanding[1:0] !== 2'd2) begin n_err++; $display("FAIL lim_count got=%0d exp=2", b_outstanding[1:0]); end
      s_fb_valid = 1'b1;
      s_fb_msgid = {1'b0, 10'd5};
      s_fb_addr  = 32'hCAFE_0000;
      s_fb_size  = 32'd256;
      #1;
      n_cmp++; if (b_s_fb_ready !== 1'b1) begin n_err++; $display("FAIL lim_fb_ready got=%b exp=1", b_s_fb_ready); end
      n_cmp++; if (b_s_her_ready !== 2'b00) begin n_err++; $display("FAIL lim_same_cycle_mask got=%b exp=00", b_s_her_ready); end
      tick();
      s_fb_valid = 1'b0;
      #1;
      n_cmp++; if (b_m_fb_valid !== 2'b01) begin n_err++; $display("FAIL lim_fb_valid got=%b exp=01", b_m_fb_valid); end
      n_cmp++; if (b_m_fb_msgid[9:0] !== 10'd5) begin n_err++; $display("FAIL lim_fb_msgid got=%0d exp=5", b_m_fb_msgid[9:0]); end
      n_cmp++; if (b_m_fb_addr[31:0] !== 32'hCAFE_0000 || b_m_fb_size[31:0] !== 32'd256) begin n_err++; $display("FAIL lim_fb_data got=%h/%0d exp=cafe0000/256", b_m_fb_addr[31:0], b_m_fb_size[31:0]); end
      n_cmp++; if (b_outstanding[1:0] !== 2'd1) begin n_err++; $display("FAIL lim_dec got=%0d exp=1", b_outstanding[1:0]); end
      n_cmp++; if (b_s_her_ready !== 2'b01) begin n_err++; $display("FAIL lim_unmask got=%b exp=01", b_s_her_ready); end
      tick();
      n_cmp++; if (b_outstanding[1:0] !== 2'd2 || b_m_her_msgid !== 11'h011) begin n_err++; $display("FAIL lim_third got=%0d/%h exp=2/011", b_outstanding[1:0], b_m_her_msgid); end
      n_cmp++; if (b_s_fb_ready !== 1'b0) begin n_err++; $display("FAIL lim_fb_backpressure got=%b exp=0", b_s_fb_ready); end
      s_fb_msgid = {1'b1, 10'd0};
      #1;
      n_cmp++; if (b_s_fb_ready !== 1'b1) begin n_err++; $display("FAIL lim_fb_other_port got=%b exp=1", b_s_fb_ready); end
      s_her_valid = 2'b00;
   endtask

   task automatic test_stall;
      do_reset();
      s_her_valid = 2'b01;
      tick();
      s_her_msgid[9:0]  = 10'h3FF;
      s_her_addr[31:0]  = 32'h1234_5678;
      s_her_valid       = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if (a_s_her_ready !== 2'b00) begin n_err++; $display("FAIL stall_ready k=%0d got=%b exp=00", k, a_s_her_ready); end
         n_cmp++; if (a_m_her_valid !== 1'b1 || a_m_her_msgid !== 11'h011 || a_m_her_addr !== 32'hA000_0000)
            begin n_err++; $display("FAIL stall_hold k=%0d got=%b/%h/%h exp=1/011/a0000000", k, a_m_her_valid, a_m_her_msgid, a_m_her_addr); end
         tick();
      end
      m_her_ready = 1'b1;
      #1;
      n_cmp++; if (a_s_her_ready !== 2'b10) begin n_err++; $display("FAIL stall_release_grant got=%b exp=10", a_s_her_ready); end
      tick();
      n_cmp++; if (a_m_her_valid !== 1'b1 || a_m_her_msgid !== 11'h422) begin n_err++; $display("FAIL stall_next got=%b/%h exp=1/422", a_m_her_valid, a_m_her_msgid); end
      s_her_valid = 2'b00;
   endtask

   task automatic test_fb_err;
      do_reset();
      s_fb_valid = 1'b1;
      s_fb_msgid = {1'b1, 10'h07};
      #1;
      n_cmp++; if (a_s_fb_ready !== 1'b1) begin n_err++; $display("FAIL err_accept got=%b exp=1", a_s_fb_ready); end
      tick();
      s_fb_valid = 1'b0;
      #1;
      n_cmp++; if (a_fb_err !== 1'b1) begin n_err++; $display("FAIL err_flag got=%b exp=1", a_fb_err); end
      n_cmp++; if (a_m_fb_valid !== 2'b00) begin n_err++; $display("FAIL err_no_forward got=%b exp=00", a_m_fb_valid); end
      n_cmp++; if (a_outstanding !== 6'd0) begin n_err++; $display("FAIL err_count got=%b exp=0", a_outstanding); end
      tick();
      tick();
      n_cmp++; if (a_fb_err !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%b exp=1", a_fb_err); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      m_her_ready = 1'b1;
      m_fb_ready  = 2'b11;
      s_her_valid = 2'b10;
      repeat (3) tick();
      n_cmp++; if (a_outstanding[5:3] !== 3'd3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", a_outstanding[5:3]); end
      s_fb_valid = 1'b1;
      s_fb_msgid = {1'b1, 10'h009};
      #1;
      n_cmp++; if (a_s_her_ready !== 2'b10 || a_s_fb_ready !== 1'b1) begin n_err++; $display("FAIL b2b_both_ready got=%b/%b exp=10/1", a_s_her_ready, a_s_fb_ready); end
      tick();
      n_cmp++; if (a_outstanding[5:3] !== 3'd3) begin n_err++; $display("FAIL b2b_same_port got=%0d exp=3", a_outstanding[5:3]); end
      n_cmp++; if (a_m_fb_valid !== 2'b10 || a_m_fb_msgid[19:10] !== 10'h009) begin n_err++; $display("FAIL b2b_fb got=%b/%h exp=10/009", a_m_fb_valid, a_m_fb_msgid[19:10]); end
      s_her_valid = 2'b01;
      tick();
      n_cmp++; if (a_outstanding !== 6'b010_001) begin n_err++; $display("FAIL b2b_diff_ports got=%b exp=010001", a_outstanding); end
      s_fb_valid  = 1'b0;
      s_her_valid = 2'b11;
      rst = 1'b1;
      #1;
      n_cmp++; if (a_m_her_valid !== 1'b0 || a_m_fb_valid !== 2'b00) begin n_err++; $display("FAIL midrst_valids got=%b/%b exp=0/00", a_m_her_valid, a_m_fb_valid); end
      n_cmp++; if (a_outstanding !== 6'd0 || b_outstanding !== 4'd0) begin n_err++; $display("FAIL midrst_counts got=%b/%b exp=0/0", a_outstanding, b_outstanding); end
      @(posedge clk);
      #1 rst = 1'b0;
      s_her_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_limit_feedback();
      test_stall();
      test_fb_err();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
